credit_tx_port: RTL and testbench

Transmit end of the credit-based latency-insensitive link. Accepts words from a producer pearl over a valid/ready handshake and forwards them to a downstream credit receiver's FIFO as registered `o_valid`/`o_data` enqueue pulses. Holds a credit counter sized to the downstream FIFO depth and consumes one credit per word sent. Each `i_increment_count` pulse returned by the receiver restores one credit. The block never sends without a credit, so the downstream FIFO cannot overflow.

---
 rtl/credit_tx_port.sv | 47 ++++
 tb/tb_credit_tx_port.sv | 121 ++++++++++++
 2 files changed

// File: rtl/credit_tx_port.sv
// credit_tx_port: credit-based link transmitter; define CREDIT_TX_RETURN_REG_EN to flop credit returns
module credit_tx_port #(
  parameter int DATA_WIDTH = 17,
  parameter int FIFO_ADDR = 3,
  localparam int N_CREDITS = 2 ** FIFO_ADDR,
  localparam int CW = $clog2(N_CREDITS + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  input  logic                         i_increment_count,
  output logic [CW-1:0]                o_credits,
  output logic                         o_error
);
  logic [CW-1:0] credits;
  logic send, ret, sat;
`ifdef CREDIT_TX_RETURN_REG_EN
  logic ret_q;
  always_ff @(posedge clock) ret_q <= reset ? 1'b0 : i_increment_count;
  always_comb ret = ret_q;
`else
  always_comb ret = i_increment_count;
`endif
  always_comb begin
    o_ready = credits != '0;
    o_credits = credits;
    send = i_valid && o_ready;
    sat = credits == CW'(N_CREDITS) && ret && !send;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      credits <= CW'(N_CREDITS);
      o_valid <= 1'b0;
      o_data <= '0;
      o_error <= 1'b0;
    end else begin
      o_valid <= send;
      if (send) o_data <= i_data;
      if (sat) o_error <= 1'b1;
      else credits <= credits - CW'(send) + CW'(ret);
    end
  end
endmodule

// File: tb/tb_credit_tx_port.sv
// tb_credit_tx_port: directed vectors and corner sequences for credit_tx_port
module tb_credit_tx_port;
`ifdef CREDIT_TX_RETURN_REG_EN
  localparam int RL = 1;
`else
  localparam int RL = 0;
`endif
  logic clock = 1'b0, reset, i_valid, i_increment_count, o_ready, o_valid, o_error;
  logic signed [16:0] i_data, o_data;
  logic [3:0] o_credits;
  int total = 0, bad = 0;
  typedef struct {
    logic rst, valid;
    int data, credits, ready, ovalid, odata, err;
  } vec_t;
  vec_t tbl[12];
  credit_tx_port dut (
    .clock(clock), .reset(reset), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_increment_count(i_increment_count),
    .o_credits(o_credits), .o_error(o_error)
  );
  always #5 clock = ~clock;
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int c, input int r, input int v, input int d, input int e);
    chk({tag, " credits"}, int'(o_credits), c);
    chk({tag, " ready"}, int'(o_ready), r);
    chk({tag, " valid"}, int'(o_valid), v);
    chk({tag, " data"}, int'(o_data), d);
    chk({tag, " error"}, int'(o_error), e);
  endtask
  initial begin
    tbl[0] = '{1, 0, 0, 8, 1, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 8, 1, 0, 0, 0};
    for (int k = 1; k <= 10; k++)
      tbl[k+1] = k <= 8 ? '{0, 1, k, 8 - k, int'(k < 8), 1, k, 0} : '{0, 1, k, 0, 0, 0, 8, 0};
    reset = 1'b1;
    i_valid = 1'b0;
    i_data = '0;
    i_increment_count = 1'b0;
    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst;
      i_valid = tbl[i].valid;
      i_data = 17'(tbl[i].data);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].credits, tbl[i].ready, tbl[i].ovalid, tbl[i].odata, tbl[i].err);
    end
    i_valid = 1'b1;
    i_data = 17'sd9;
    i_increment_count = 1'b1;
    step();
    i_increment_count = 1'b0;
    repeat (RL) step();
    chk_all("ret_rise", 1, 1, 0, 8, 0);
    step();
    chk_all("ret_send", 0, 0, 1, 9, 0);
    i_valid = 1'b0;
    step();
    chk_all("ret_after", 0, 0, 0, 9, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    i_valid = 1'b1;
    for (int k = 31; k <= 33; k++) begin
      i_data = 17'(k);
      step();
    end
    i_valid = 1'b0;
    chk_all("at5", 5, 1, 1, 33, 0);
    i_increment_count = 1'b1;
    repeat (RL) step();
    i_increment_count = RL == 0;
    i_valid = 1'b1;
    i_data = 17'sh55;
    step();
    i_increment_count = 1'b0;
    i_valid = 1'b0;
    chk_all("sendret", 5, 1, 1, 'h55, 0);
    step();
    chk_all("sendret_idle", 5, 1, 0, 'h55, 0);
    i_increment_count = 1'b1;
    repeat (3) step();
    i_increment_count = 1'b0;
    repeat (RL) step();
    chk_all("refill", 8, 1, 0, 'h55, 0);
    i_increment_count = 1'b1;
    step();
    i_increment_count = 1'b0;
    repeat (RL) step();
    chk_all("overflow", 8, 1, 0, 'h55, 1);
    repeat (3) step();
    chk("sticky_idle error", int'(o_error), 1);
    i_valid = 1'b1;
    for (int k = 21; k <= 25; k++) begin
      i_data = 17'(k);
      step();
    end
    chk_all("midburst", 3, 1, 1, 25, 1);
    reset = 1'b1;
    i_increment_count = 1'b1;
    i_data = 17'sd26;
    step();
    chk_all("rst_mid", 8, 1, 0, 0, 0);
    reset = 1'b0;
    i_increment_count = 1'b0;
    i_valid = 1'b0;
    repeat (RL + 1) step();
    chk_all("rst_ret_ignored", 8, 1, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
